// File: rtl/rx_lane_router_if.sv
// ---------------------------------------------------------------------------
// rx_lane_router_if
// Configuration handshake between a controller and rx_lane_router.
//
// Signals:
//   cfg_valid  - controller presents a source-change request
//   cfg_ready  - router can accept a request this cycle
//   cfg_dac    - target DAC index of the request
//   cfg_source - requested source (0 DSP, 1 ADC loopback, 2 ramp, 3 zero)
//   cfg_error  - one-cycle pulse when a request names a nonexistent DAC
//
// Modports:
//   master - request side (controller / testbench)
//   slave  - router side
// ---------------------------------------------------------------------------
interface rx_lane_router_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_dac;
  logic [1:0] cfg_source;
  logic       cfg_error;

  modport master (
    output cfg_valid,
    output cfg_dac,
    output cfg_source,
    input  cfg_ready,
    input  cfg_error
  );

  modport slave (
    input  cfg_valid,
    input  cfg_dac,
    input  cfg_source,
    output cfg_ready,
    output cfg_error
  );
endinterface

// File: rtl/rx_lane_router.sv
// ---------------------------------------------------------------------------
// rx_lane_router
// Routes one of four sources onto each DAC stream: the DSP core output, a
// registered ADC loopback, a free-running ramp, or zero. Changing a DAC's
// source mutes that DAC for MUTE_CYCLES edges before the new source is
// committed, so the analog path never sees an abrupt source splice.
//
// Ports:
//   clock      - single rising-edge clock
//   reset_n    - asynchronous active-low reset
//   adc_data   - ADC lanes, lane i at [SW*(i+1)-1 : SW*i]
//   dsp_data   - DSP lanes, DAC d lane i at slice (d*NL+i)
//   cfg        - configuration handshake (slave modport)
//   dac_data   - registered DAC lanes, same slicing as dsp_data
//   dac_source - committed source per DAC, DAC d at [2d+1:2d]
// ---------------------------------------------------------------------------
module rx_lane_router #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int NUMBER_OF_DAC  = 3,
  parameter int MUTE_CYCLES    = 16
) (
  input  logic                                                 clock,
  input  logic                                                 reset_n,
  input  logic [SAMPLE_WIDTH*NUMBER_OF_LINE-1:0]               adc_data,
  input  logic [SAMPLE_WIDTH*NUMBER_OF_LINE*NUMBER_OF_DAC-1:0] dsp_data,
  rx_lane_router_if.slave                                      cfg,
  output logic [SAMPLE_WIDTH*NUMBER_OF_LINE*NUMBER_OF_DAC-1:0] dac_data,
  output logic [2*NUMBER_OF_DAC-1:0]                           dac_source
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int NL = NUMBER_OF_LINE;
  localparam int LW = SW * NL;
  localparam int TW = LW * NUMBER_OF_DAC;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MUTE   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [7:0] MUTE_LOAD = 8'(MUTE_CYCLES - 1);

  logic [LW-1:0] adc_q;
  logic [SW-1:0] ramp_base;
  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [7:0]    mute_cnt;
  logic [7:0]    next_cnt;
  logic [1:0]    target_dac;
  logic [1:0]    target_src;
  logic          accept;
  logic          dac_in_range;
  logic          start_switch;
  logic [1:0]    cur_src;
  logic [TW-1:0] dac_next;

  assign accept = cfg.cfg_valid && cfg.cfg_ready;

  // Classify an accepted request: out-of-range DAC, no-op (source already
  // committed), or a real switch that has to go through the mute sequence.
  always_comb begin
    dac_in_range = (int'(cfg.cfg_dac) < NUMBER_OF_DAC);
    cur_src      = 2'd0;
    for (int d = 0; d < NUMBER_OF_DAC; d++) begin
      if (cfg.cfg_dac == 2'(d)) begin
        cur_src = dac_source[2*d +: 2];
      end
    end
    start_switch = accept && dac_in_range && (cfg.cfg_source != cur_src);
  end

  // The counter is loaded with MUTE_CYCLES-1 and MUTE is left when it reads
  // zero, which gives exactly MUTE_CYCLES muted edges.
  always_comb begin
    next_state = state;
    next_cnt   = mute_cnt;
    case (state)
      IDLE: begin
        if (start_switch) begin
          next_state = MUTE;
          next_cnt   = MUTE_LOAD;
        end
      end
      MUTE: begin
        if (mute_cnt == 8'd0) begin
          next_state = COMMIT;
        end else begin
          next_cnt = mute_cnt - 8'd1;
        end
      end
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // cfg_ready is registered so it stays low throughout reset and rises on the
  // first edge afterwards; it tracks whether the FSM is heading into IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mute_cnt      <= 8'd0;
      target_dac    <= 2'd0;
      target_src    <= 2'd0;
      cfg.cfg_ready <= 1'b0;
      cfg.cfg_error <= 1'b0;
      dac_source    <= '0;
    end else begin
      state         <= next_state;
      mute_cnt      <= next_cnt;
      cfg.cfg_ready <= (next_state == IDLE);
      cfg.cfg_error <= accept && !dac_in_range;
      if (start_switch) begin
        target_dac <= cfg.cfg_dac;
        target_src <= cfg.cfg_source;
      end
      if (state == COMMIT) begin
        for (int d = 0; d < NUMBER_OF_DAC; d++) begin
          if (target_dac == 2'(d)) begin
            dac_source[2*d +: 2] <= target_src;
          end
        end
      end
    end
  end

  // Source mux. During COMMIT the target already takes its new source so the
  // first post-mute edge carries new data, one cycle before dac_source is
  // visibly updated would otherwise allow.
  always_comb begin
    logic [1:0] src;
    logic       muted;
    dac_next = '0;
    for (int d = 0; d < NUMBER_OF_DAC; d++) begin
      src   = dac_source[2*d +: 2];
      muted = 1'b0;
      if (target_dac == 2'(d)) begin
        if (state == MUTE) begin
          muted = 1'b1;
        end
        if (state == COMMIT) begin
          src = target_src;
        end
      end
      for (int i = 0; i < NL; i++) begin
        if (!muted) begin
          case (src)
            2'd0:    dac_next[(d*NL+i)*SW +: SW] = dsp_data[(d*NL+i)*SW +: SW];
            2'd1:    dac_next[(d*NL+i)*SW +: SW] = adc_q[i*SW +: SW];
            2'd2:    dac_next[(d*NL+i)*SW +: SW] = ramp_base + SW'(i);
            default: dac_next[(d*NL+i)*SW +: SW] = '0;
          endcase
        end
      end
    end
  end

  // Datapath registers: ADC capture, ramp generator and the DAC outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      adc_q     <= '0;
      ramp_base <= '0;
      dac_data  <= '0;
    end else begin
      adc_q     <= adc_data;
      ramp_base <= ramp_base + SW'(NL);
      dac_data  <= dac_next;
    end
  end

endmodule

// File: tb/tb_rx_lane_router.sv
// ---------------------------------------------------------------------------
// tb_rx_lane_router
// Self-checking bench for rx_lane_router with default parameters
// (8 lanes, 16-bit samples, 3 DACs, 16 mute cycles). Inputs are driven and
// outputs sampled on the falling edge; per-DAC expectations are queued when
// stimulus is driven and popped once the DUT has registered them.
// ---------------------------------------------------------------------------
module tb_rx_lane_router;

  localparam int NL  = 8;
  localparam int SW  = 16;
  localparam int NOD = 3;
  localparam int LW  = SW * NL;
  localparam int TW  = LW * NOD;

  typedef struct {
    int            due;
    int            dac;
    logic [LW-1:0] val;
  } exp_t;

  logic          clock;
  logic          reset_n;
  logic [LW-1:0] adc_data;
  logic [TW-1:0] dsp_data;
  logic [TW-1:0] dac_data;
  logic [5:0]    dac_source;

  rx_lane_router_if cfg_if ();

  rx_lane_router #(
    .NUMBER_OF_LINE (NL),
    .SAMPLE_WIDTH   (SW),
    .NUMBER_OF_DAC  (NOD),
    .MUTE_CYCLES    (16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .adc_data   (adc_data),
    .dsp_data   (dsp_data),
    .cfg        (cfg_if),
    .dac_data   (dac_data),
    .dac_source (dac_source)
  );

  exp_t          sb[$];
  int            checks = 0;
  int            passes = 0;
  int            cyc    = 0;
  logic [SW-1:0] rmodel;
  logic [LW-1:0] adc_prev;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected ramp base: 8 per edge from zero after reset.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) rmodel <= '0;
    else          rmodel <= rmodel + 16'd8;
  end

  // New random DSP and ADC words; remembers the ADC word that adc_q holds.
  task automatic drive_random();
    adc_prev = adc_data;
    for (int w = 0; w < LW / 32; w++) adc_data[w*32 +: 32] = $urandom;
    for (int w = 0; w < TW / 32; w++) dsp_data[w*32 +: 32] = $urandom;
  endtask

  // Queue what each DAC must show after the coming edge (3 means zero/muted).
  task automatic push_expect(input int s0, input int s1, input int s2);
    int   src[3];
    exp_t e;
    src = '{s0, s1, s2};
    for (int d = 0; d < NOD; d++) begin
      e.due = cyc + 1;
      e.dac = d;
      e.val = '0;
      for (int i = 0; i < NL; i++) begin
        case (src[d])
          0:       e.val[i*SW +: SW] = dsp_data[(d*NL+i)*SW +: SW];
          1:       e.val[i*SW +: SW] = adc_prev[i*SW +: SW];
          2:       e.val[i*SW +: SW] = rmodel + 16'(i);
          default: e.val[i*SW +: SW] = '0;
        endcase
      end
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_dac = 2'd0;
    cfg_if.cfg_source = 2'd0;
    drive_random();
    repeat (3) @(negedge clock);
    checks++; if (dac_data !== '0) $display("[TB] FAIL reset_data got %h want 0", dac_data); else passes++;
    checks++; if (dac_source !== 6'd0) $display("[TB] FAIL reset_source got %h want 0", dac_source); else passes++;
    checks++; if (cfg_if.cfg_ready !== 1'b0) $display("[TB] FAIL reset_ready got %b want 0", cfg_if.cfg_ready); else passes++;
    checks++; if (cfg_if.cfg_error !== 1'b0) $display("[TB] FAIL reset_error got %b want 0", cfg_if.cfg_error); else passes++;
    reset_n = 1'b1;
    adc_prev = adc_data;
    for (int k = 0; k < NL * NOD; k++) dsp_data[k*SW +: SW] = 16'h1234;
    push_expect(0, 0, 0);
    @(negedge clock);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (dac_data[e.dac*LW +: LW] !== e.val) $display("[TB] FAIL reset_dsp dac%0d got %h want %h", e.dac, dac_data[e.dac*LW +: LW], e.val);
      else passes++;
    end
    checks++; if (cfg_if.cfg_ready !== 1'b1) $display("[TB] FAIL ready_after_reset got %b want 1", cfg_if.cfg_ready); else passes++;
    checks++; if (dac_source !== 6'd0) $display("[TB] FAIL source_after_reset got %h want 0", dac_source); else passes++;
  endtask

  task automatic test_ramp_switch();
    exp_t e;
    int   n = 0;
    while (rmodel != 16'hFF70 && n < 10000) begin
      @(negedge clock);
      n++;
    end
    checks++; if (rmodel !== 16'hFF70) $display("[TB] FAIL ramp_wait got %h want ff70", rmodel); else passes++;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_dac = 2'd1;
    cfg_if.cfg_source = 2'd2;
    for (int k = 0; k <= 20; k++) begin
      drive_random();
      push_expect(0, (k == 0) ? 0 : (k <= 16) ? 3 : 2, 0);
      @(negedge clock);
      cfg_if.cfg_valid = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (dac_data[e.dac*LW +: LW] !== e.val) $display("[TB] FAIL ramp k%0d dac%0d got %h want %h", k, e.dac, dac_data[e.dac*LW +: LW], e.val);
        else passes++;
      end
      checks++;
      if (cfg_if.cfg_ready !== (k >= 17)) $display("[TB] FAIL ramp_ready k%0d got %b want %b", k, cfg_if.cfg_ready, k >= 17);
      else passes++;
      checks++;
      if (dac_source !== ((k >= 17) ? 6'b001000 : 6'b000000)) $display("[TB] FAIL ramp_source k%0d got %b", k, dac_source);
      else passes++;
      if (k == 17) begin
        checks++;
        if (dac_data[(NL+0)*SW +: SW] !== 16'hFFF8) $display("[TB] FAIL ramp_pre_wrap got %h want fff8", dac_data[(NL+0)*SW +: SW]);
        else passes++;
      end
      if (k == 18) begin
        checks++;
        if (dac_data[(NL+0)*SW +: SW] !== 16'h0000) $display("[TB] FAIL ramp_wrap_l0 got %h want 0000", dac_data[(NL+0)*SW +: SW]);
        else passes++;
        checks++;
        if (dac_data[(NL+7)*SW +: SW] !== 16'h0007) $display("[TB] FAIL ramp_wrap_l7 got %h want 0007", dac_data[(NL+7)*SW +: SW]);
        else passes++;
      end
    end
  endtask

  task automatic test_adc_loopback();
    exp_t e;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_dac = 2'd0;
    cfg_if.cfg_source = 2'd1;
    for (int k = 0; k <= 19; k++) begin
      drive_random();
      if (k == 16) adc_data[3*SW +: SW] = 16'h8001;
      push_expect((k == 0) ? 0 : (k <= 16) ? 3 : 1, 2, 0);
      @(negedge clock);
      cfg_if.cfg_valid = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (dac_data[e.dac*LW +: LW] !== e.val) $display("[TB] FAIL adc k%0d dac%0d got %h want %h", k, e.dac, dac_data[e.dac*LW +: LW], e.val);
        else passes++;
      end
      if (k == 17) begin
        checks++;
        if (dac_data[3*SW +: SW] !== 16'h8001) $display("[TB] FAIL adc_lane3 got %h want 8001", dac_data[3*SW +: SW]);
        else passes++;
      end
    end
    checks++; if (dac_source !== 6'b001001) $display("[TB] FAIL adc_source got %b want 001001", dac_source); else passes++;
  endtask

  task automatic test_bad_dac();
    exp_t e;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_dac = 2'd3;
    cfg_if.cfg_source = 2'd3;
    for (int k = 0; k < 3; k++) begin
      drive_random();
      push_expect(1, 2, 0);
      @(negedge clock);
      cfg_if.cfg_valid = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (dac_data[e.dac*LW +: LW] !== e.val) $display("[TB] FAIL bad_dac k%0d dac%0d got %h want %h", k, e.dac, dac_data[e.dac*LW +: LW], e.val);
        else passes++;
      end
      checks++;
      if (cfg_if.cfg_error !== (k == 0)) $display("[TB] FAIL bad_dac_error k%0d got %b want %b", k, cfg_if.cfg_error, k == 0);
      else passes++;
      checks++;
      if (cfg_if.cfg_ready !== 1'b1) $display("[TB] FAIL bad_dac_ready k%0d got %b want 1", k, cfg_if.cfg_ready);
      else passes++;
    end
    checks++; if (dac_source !== 6'b001001) $display("[TB] FAIL bad_dac_source got %b want 001001", dac_source); else passes++;
  endtask

  task automatic test_same_source();
    exp_t e;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_dac = 2'd1;
    cfg_if.cfg_source = 2'd2;
    for (int k = 0; k < 3; k++) begin
      drive_random();
      push_expect(1, 2, 0);
      @(negedge clock);
      cfg_if.cfg_valid = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (dac_data[e.dac*LW +: LW] !== e.val) $display("[TB] FAIL same_src k%0d dac%0d got %h want %h", k, e.dac, dac_data[e.dac*LW +: LW], e.val);
        else passes++;
      end
      checks++;
      if (cfg_if.cfg_ready !== 1'b1 || cfg_if.cfg_error !== 1'b0) $display("[TB] FAIL same_src_hs k%0d got ready %b error %b want 1 0", k, cfg_if.cfg_ready, cfg_if.cfg_error);
      else passes++;
    end
  endtask

  task automatic test_reset_during_mute();
    exp_t e;
    int   n = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_dac = 2'd2;
    cfg_if.cfg_source = 2'd2;
    for (int k = 0; k <= 5; k++) begin
      drive_random();
      push_expect(1, 2, (k == 0) ? 0 : 3);
      @(negedge clock);
      cfg_if.cfg_valid = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (dac_data[e.dac*LW +: LW] !== e.val) $display("[TB] FAIL mute_rst k%0d dac%0d got %h want %h", k, e.dac, dac_data[e.dac*LW +: LW], e.val);
        else passes++;
      end
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_dac = 2'd2;
    cfg_if.cfg_source = 2'd1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (dac_data !== '0) $display("[TB] FAIL async_reset_data got %h want 0", dac_data); else passes++;
    checks++; if (dac_source !== 6'd0) $display("[TB] FAIL async_reset_source got %b want 0", dac_source); else passes++;
    checks++; if (cfg_if.cfg_ready !== 1'b0) $display("[TB] FAIL async_reset_ready got %b want 0", cfg_if.cfg_ready); else passes++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_random();
      push_expect(0, 0, (k == 2) ? 3 : 0);
      @(negedge clock);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (dac_data[e.dac*LW +: LW] !== e.val) $display("[TB] FAIL post_rst k%0d dac%0d got %h want %h", k, e.dac, dac_data[e.dac*LW +: LW], e.val);
        else passes++;
      end
      if (k == 0) begin
        checks++;
        if (cfg_if.cfg_ready !== 1'b1 || dac_source !== 6'd0) $display("[TB] FAIL post_rst_idle got ready %b source %b want 1 0", cfg_if.cfg_ready, dac_source);
        else passes++;
      end
      if (k == 1) begin
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) $display("[TB] FAIL held_valid_accept got ready %b want 0", cfg_if.cfg_ready);
        else passes++;
        cfg_if.cfg_valid = 1'b0;
      end
    end
    while (cfg_if.cfg_ready !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++; if (cfg_if.cfg_ready !== 1'b1) $display("[TB] FAIL held_commit_timeout got ready %b want 1", cfg_if.cfg_ready); else passes++;
    checks++; if (dac_source !== 6'b010000) $display("[TB] FAIL held_commit_source got %b want 010000", dac_source); else passes++;
  endtask

  initial begin
    adc_data = '0;
    dsp_data = '0;
    adc_prev = '0;
    test_reset();
    test_ramp_switch();
    test_adc_loopback();
    test_bad_dac();
    test_same_source();
    test_reset_during_mute();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
